// File: rtl/mobo_pkg.sv
// Shared definitions for the MOBO readout FSM: state encodings, host
// status codes and datapath widths.
package mobo_pkg;

  localparam int ROW_W = 8;
  localparam int TMR_W = 16;

  localparam logic [7:0] STAT_RESET = 8'hAA;

  // One-hot state encoding
  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_ACK1     = 8'b0000_0010,
    S_SETUP    = 8'b0000_0100,
    S_RST      = 8'b0000_1000,
    S_SIG      = 8'b0001_0000,
    S_CONV     = 8'b0010_0000,
    S_HANDBACK = 8'b0100_0000,
    S_WAIT0    = 8'b1000_0000
  } state_e;

  // Compact state code reported on fsm_stat for debug/host readback
  function automatic logic [7:0] stat_code(state_e s);
    case (s)
      S_IDLE:     return 8'h01;
      S_ACK1:     return 8'h02;
      S_SETUP:    return 8'h03;
      S_RST:      return 8'h04;
      S_SIG:      return 8'h05;
      S_CONV:     return 8'h06;
      S_HANDBACK: return 8'h07;
      S_WAIT0:    return 8'h08;
      default:    return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/fsm_ind_sync.sv
// Two-flop level synchronizer for the handshake lines coming from the
// exposure FSM clock domain.
module fsm_ind_sync (
  input  logic CLKMPRE,
  input  logic RESET,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Metastability filter; both stages clear on reset so a stale level
  // never leaks into the FSM after reset.
  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mobo_readout_fsm.sv
// ADC-side readout sequencer. Answers the exposure FSM's readout request,
// walks C_NUM_ROWS rows through setup/reset-sample/signal-sample/convert,
// then hands control back with a 4-phase FSMIND0/FSMIND0ACK handshake.
// All outputs are registered from next-state values, so they line up with
// the state register and have no combinational path from the inputs.
module mobo_readout_fsm
  import mobo_pkg::*;
#(
  parameter int C_NUM_ROWS = 160,
  parameter int C_T_SETUP  = 4,
  parameter int C_T_RST    = 8,
  parameter int C_T_SIG    = 8,
  parameter int C_T_CONV   = 18
) (
  input  logic        CLKMPRE,
  input  logic        RESET,
  input  logic        FSMIND1,
  output logic        FSMIND1ACK,
  output logic        FSMIND0,
  input  logic        FSMIND0ACK,
  input  logic        FIFO_FULL,
  output logic [7:0]  ROW_ADDR,
  output logic        ROW_SEL,
  output logic        SAMPLE_RST,
  output logic        SAMPLE_SIG,
  output logic        ADC_START,
  output logic        ROW_DONE,
  output logic [31:0] CntFrame,
  output logic [7:0]  fsm_stat
);

  localparam logic [TMR_W-1:0] T_SETUP_END = TMR_W'(C_T_SETUP - 1);
  localparam logic [TMR_W-1:0] T_RST_END   = TMR_W'(C_T_RST - 1);
  localparam logic [TMR_W-1:0] T_SIG_END   = TMR_W'(C_T_SIG - 1);
  localparam logic [TMR_W-1:0] T_CONV_END  = TMR_W'(C_T_CONV - 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(C_NUM_ROWS - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               row_inc, row_clr;
  logic               s1, s0a;

  logic               ack1_q, ack1_d;
  logic               ind0_q, ind0_d;
  logic [ROW_W-1:0]   addr_q, addr_d;
  logic               rsel_q, rsel_d;
  logic               srst_q, srst_d;
  logic               ssig_q, ssig_d;
  logic               adc_q, adc_d;
  logic               done_q, done_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [7:0]         stat_q, stat_d;

  fsm_ind_sync u_sync_ind1 (
    .CLKMPRE (CLKMPRE),
    .RESET   (RESET),
    .d_i     (FSMIND1),
    .q_o     (s1)
  );

  fsm_ind_sync u_sync_ind0ack (
    .CLKMPRE (CLKMPRE),
    .RESET   (RESET),
    .d_i     (FSMIND0ACK),
    .q_o     (s0a)
  );

  // State register
  always_ff @(posedge CLKMPRE) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; also decides when the row index advances or clears
  always_comb begin
    state_d = state_q;
    row_inc = 1'b0;
    row_clr = 1'b0;
    case (state_q)
      S_IDLE:     if (s1) state_d = S_ACK1;
      S_ACK1: begin
        row_clr = 1'b1;
        state_d = S_SETUP;
      end
      // FIFO_FULL is only honoured here, so a row already sampling runs to
      // completion even if the FIFO fills meanwhile.
      S_SETUP:    if (!FIFO_FULL && timer_q == T_SETUP_END) state_d = S_RST;
      S_RST:      if (timer_q == T_RST_END) state_d = S_SIG;
      S_SIG:      if (timer_q == T_SIG_END) state_d = S_CONV;
      S_CONV: begin
        if (timer_q == T_CONV_END) begin
          if (row_q == LAST_ROW) begin
            state_d = S_HANDBACK;
          end else begin
            row_inc = 1'b1;
            state_d = S_SETUP;
          end
        end
      end
      S_HANDBACK: state_d = S_WAIT0;
      // Release only once the exposure side has both seen FSMIND0 and
      // dropped its request; FSMIND1 dropping earlier is ignored.
      S_WAIT0: begin
        if (s0a && !s1) begin
          row_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        row_clr = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Phase timer and row index next values; timer restarts on every state
  // change and is pinned to zero while a FIFO stall holds the setup phase.
  always_comb begin
    timer_d = timer_q + TMR_W'(1);
    row_d   = row_q;
    if (state_d != state_q ||
        !(state_q inside {S_SETUP, S_RST, S_SIG, S_CONV}) ||
        (state_q == S_SETUP && FIFO_FULL))
      timer_d = '0;
    if (row_clr)      row_d = '0;
    else if (row_inc) row_d = row_q + ROW_W'(1);
  end

  // Timer / row counter registers
  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      timer_q <= '0;
      row_q   <= '0;
    end else begin
      timer_q <= timer_d;
      row_q   <= row_d;
    end
  end

  // Output next values, derived from where the FSM is heading this edge
  always_comb begin
    rsel_d = state_d inside {S_SETUP, S_RST, S_SIG, S_CONV};
    addr_d = rsel_d ? row_d : '0;
    srst_d = (state_d == S_RST);
    ssig_d = (state_d == S_SIG);
    adc_d  = (state_d == S_CONV) && (timer_d == '0);
    done_d = (state_d == S_CONV) && (timer_d == T_CONV_END);
    ack1_d = state_d inside {S_ACK1, S_SETUP, S_RST, S_SIG, S_CONV,
                             S_HANDBACK, S_WAIT0};
    ind0_d = state_d inside {S_HANDBACK, S_WAIT0};
    cnt_d  = cnt_q;
    if (state_d == S_HANDBACK && state_q != S_HANDBACK)
      cnt_d = cnt_q + 32'd1;
    stat_d = stat_code(state_d);
  end

  // Output registers
  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      rsel_q <= 1'b0;
      addr_q <= '0;
      srst_q <= 1'b0;
      ssig_q <= 1'b0;
      adc_q  <= 1'b0;
      done_q <= 1'b0;
      ack1_q <= 1'b0;
      ind0_q <= 1'b0;
      cnt_q  <= '0;
      stat_q <= STAT_RESET;
    end else begin
      rsel_q <= rsel_d;
      addr_q <= addr_d;
      srst_q <= srst_d;
      ssig_q <= ssig_d;
      adc_q  <= adc_d;
      done_q <= done_d;
      ack1_q <= ack1_d;
      ind0_q <= ind0_d;
      cnt_q  <= cnt_d;
      stat_q <= stat_d;
    end
  end

  assign ROW_SEL    = rsel_q;
  assign ROW_ADDR   = addr_q;
  assign SAMPLE_RST = srst_q;
  assign SAMPLE_SIG = ssig_q;
  assign ADC_START  = adc_q;
  assign ROW_DONE   = done_q;
  assign FSMIND1ACK = ack1_q;
  assign FSMIND0    = ind0_q;
  assign CntFrame   = cnt_q;
  assign fsm_stat   = stat_q;

endmodule

// File: tb/tb_mobo_readout_fsm.sv
// Directed bench for mobo_readout_fsm: handshake, frame timing, FIFO stall,
// mid-frame reset, request glitch and back-to-back frames.
module tb_mobo_readout_fsm;

  logic        CLKMPRE = 1'b0;
  logic        RESET = 1'b1;
  logic        FSMIND1 = 1'b0;
  logic        FSMIND0ACK = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        FSMIND1ACK, FSMIND0, ROW_SEL, SAMPLE_RST, SAMPLE_SIG;
  logic        ADC_START, ROW_DONE;
  logic [7:0]  ROW_ADDR, fsm_stat;
  logic [31:0] CntFrame;

  int n_cmp = 0;
  int n_bad = 0;

  // Results of the most recent run_frame call (cycle k counted from the
  // negedge at which FSMIND1 was raised).
  int k_ack, k_setup, k_adc, k_hb, n_done, n_adc, row_bad;
  int k_set_s, k_rst_s, stall_bad;
  logic [7:0] stat_hb;

  always #5 CLKMPRE = ~CLKMPRE;

  mobo_readout_fsm dut (
    .CLKMPRE    (CLKMPRE),
    .RESET      (RESET),
    .FSMIND1    (FSMIND1),
    .FSMIND1ACK (FSMIND1ACK),
    .FSMIND0    (FSMIND0),
    .FSMIND0ACK (FSMIND0ACK),
    .FIFO_FULL  (FIFO_FULL),
    .ROW_ADDR   (ROW_ADDR),
    .ROW_SEL    (ROW_SEL),
    .SAMPLE_RST (SAMPLE_RST),
    .SAMPLE_SIG (SAMPLE_SIG),
    .ADC_START  (ADC_START),
    .ROW_DONE   (ROW_DONE),
    .CntFrame   (CntFrame),
    .fsm_stat   (fsm_stat)
  );

  // Raise FSMIND1 and run one frame until FSMIND0 rises (bounded).
  // Watches row 'srow'; with 'stall' set, FIFO_FULL is held for 50 cycles
  // from that row's setup entry. glitch_k drops FSMIND1 for one cycle.
  task automatic run_frame(input bit stall, input int srow, input int glitch_k);
    int left;
    int exp_row;
    logic [7:0] sr;
    sr = 8'(srow);
    left = 0; exp_row = 0;
    k_ack = -1; k_setup = -1; k_adc = -1; k_hb = -1; n_done = 0; n_adc = 0;
    row_bad = 0; k_set_s = -1; k_rst_s = -1; stall_bad = 0; stat_hb = 8'h00;
    FSMIND1 = 1'b1;
    for (int k = 1; k <= 7000 && k_hb < 0; k++) begin
      @(negedge CLKMPRE);
      if (FIFO_FULL && (ROW_ADDR !== sr || ROW_SEL !== 1'b1)) stall_bad++;
      if (left > 0) begin
        left--;
        if (left == 0) FIFO_FULL = 1'b0;
      end
      if (k == glitch_k) FSMIND1 = 1'b0;
      else if (k == glitch_k + 1) FSMIND1 = 1'b1;
      if (FSMIND1ACK === 1'b1 && k_ack < 0) k_ack = k;
      if (fsm_stat === 8'h03 && k_setup < 0) k_setup = k;
      if (ADC_START === 1'b1) begin
        n_adc++;
        if (k_adc < 0) k_adc = k;
      end
      if (ROW_DONE === 1'b1) begin
        if (ROW_ADDR !== 8'(exp_row)) row_bad++;
        exp_row++;
        n_done++;
      end
      if (FSMIND0 === 1'b1 && k_hb < 0) begin
        k_hb = k;
        stat_hb = fsm_stat;
      end
      if (fsm_stat === 8'h03 && ROW_ADDR === sr && k_set_s < 0) begin
        k_set_s = k;
        if (stall) begin
          FIFO_FULL = 1'b1;
          left = 50;
        end
      end
      if (SAMPLE_RST === 1'b1 && ROW_ADDR === sr && k_rst_s < 0) k_rst_s = k;
    end
  endtask

  // Acknowledge handback and drop the request; returns cycles until FSMIND0 falls.
  task automatic do_release(output int k_rel);
    FSMIND0ACK = 1'b1;
    FSMIND1 = 1'b0;
    k_rel = -1;
    for (int k = 1; k <= 10 && k_rel < 0; k++) begin
      @(negedge CLKMPRE);
      if (FSMIND0 === 1'b0) k_rel = k;
    end
    FSMIND0ACK = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    RESET = 1'b1;
    repeat (3) @(negedge CLKMPRE);
    outs = {FSMIND1ACK, FSMIND0, ROW_SEL, SAMPLE_RST, SAMPLE_SIG, ADC_START,
            ROW_DONE, ROW_ADDR[6:0]};
    n_cmp++;
    if (outs !== 14'h0 || ROW_ADDR !== 8'h00) begin
      n_bad++; $display("FAIL reset_outs: got %h/%h want 0", outs, ROW_ADDR);
    end
    n_cmp++;
    if (fsm_stat !== 8'hAA) begin
      n_bad++; $display("FAIL reset_stat: got %h want aa", fsm_stat);
    end
    n_cmp++;
    if (CntFrame !== 32'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", CntFrame);
    end
    RESET = 1'b0;
    @(negedge CLKMPRE);
    n_cmp++;
    if (fsm_stat !== 8'h01) begin
      n_bad++; $display("FAIL idle_stat: got %h want 01", fsm_stat);
    end
  endtask

  task automatic test_frame();
    int k_rel;
    run_frame(1'b0, 7, -5);
    n_cmp++;
    if (k_ack !== 3) begin n_bad++; $display("FAIL ack_cycle: got %0d want 3", k_ack); end
    n_cmp++;
    if (k_setup !== 4) begin n_bad++; $display("FAIL setup_cycle: got %0d want 4", k_setup); end
    n_cmp++;
    if (k_adc !== 24) begin n_bad++; $display("FAIL first_adc: got %0d want 24", k_adc); end
    n_cmp++;
    if (k_rst_s - k_set_s !== 4) begin
      n_bad++; $display("FAIL setup_len: got %0d want 4", k_rst_s - k_set_s);
    end
    n_cmp++;
    if (n_done !== 160 || n_adc !== 160) begin
      n_bad++; $display("FAIL frame_pulses: got %0d/%0d want 160/160", n_done, n_adc);
    end
    n_cmp++;
    if (row_bad !== 0) begin n_bad++; $display("FAIL row_seq: got %0d bad want 0", row_bad); end
    n_cmp++;
    if (k_hb !== 6084) begin n_bad++; $display("FAIL handback_cycle: got %0d want 6084", k_hb); end
    n_cmp++;
    if (stat_hb !== 8'h07) begin n_bad++; $display("FAIL handback_stat: got %h want 07", stat_hb); end
    // Acknowledge while the request is still high: must keep holding FSMIND0
    FSMIND0ACK = 1'b1;
    repeat (10) @(negedge CLKMPRE);
    n_cmp++;
    if (FSMIND0 !== 1'b1 || fsm_stat !== 8'h08) begin
      n_bad++; $display("FAIL wait0_hold: got %b/%h want 1/08", FSMIND0, fsm_stat);
    end
    do_release(k_rel);
    n_cmp++;
    if (k_rel !== 3) begin n_bad++; $display("FAIL release_cycle: got %0d want 3", k_rel); end
    n_cmp++;
    if (FSMIND1ACK !== 1'b0 || fsm_stat !== 8'h01) begin
      n_bad++; $display("FAIL release_state: got %b/%h want 0/01", FSMIND1ACK, fsm_stat);
    end
    n_cmp++;
    if (CntFrame !== 32'd1) begin n_bad++; $display("FAIL cnt_frame1: got %0d want 1", CntFrame); end
  endtask

  task automatic test_fifo_stall();
    int k_rel;
    run_frame(1'b1, 7, -5);
    n_cmp++;
    if (k_rst_s - k_set_s !== 54) begin
      n_bad++; $display("FAIL stall_delay: got %0d want 54", k_rst_s - k_set_s);
    end
    n_cmp++;
    if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_row: got %0d bad want 0", stall_bad); end
    n_cmp++;
    if (n_done !== 160 || row_bad !== 0) begin
      n_bad++; $display("FAIL stall_done: got %0d/%0d want 160/0", n_done, row_bad);
    end
    n_cmp++;
    if (k_hb !== 6134) begin n_bad++; $display("FAIL stall_handback: got %0d want 6134", k_hb); end
    do_release(k_rel);
    n_cmp++;
    if (CntFrame !== 32'd2) begin n_bad++; $display("FAIL cnt_frame2: got %0d want 2", CntFrame); end
  endtask

  task automatic test_glitch();
    int k_rel;
    run_frame(1'b0, 7, 1000);
    n_cmp++;
    if (k_hb !== 6084 || n_done !== 160) begin
      n_bad++; $display("FAIL glitch_frame: got %0d/%0d want 6084/160", k_hb, n_done);
    end
    do_release(k_rel);
    n_cmp++;
    if (CntFrame !== 32'd3 || k_rel !== 3) begin
      n_bad++; $display("FAIL glitch_cnt: got %0d/%0d want 3/3", CntFrame, k_rel);
    end
  endtask

  task automatic test_reset_midframe();
    bit found;
    int n_ind0;
    found = 1'b0;
    n_ind0 = 0;
    FSMIND1 = 1'b1;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge CLKMPRE);
      if (fsm_stat === 8'h06 && ROW_ADDR === 8'd80 && ADC_START === 1'b0) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL midframe_reach: got 0 want 1"); end
    RESET = 1'b1;
    @(negedge CLKMPRE);
    n_cmp++;
    if ({FSMIND1ACK, FSMIND0, ROW_SEL, SAMPLE_RST, SAMPLE_SIG, ADC_START, ROW_DONE} !== 7'd0 ||
        ROW_ADDR !== 8'd0) begin
      n_bad++; $display("FAIL midreset_outs: got row %0d sel %b want 0", ROW_ADDR, ROW_SEL);
    end
    n_cmp++;
    if (fsm_stat !== 8'hAA || CntFrame !== 32'd0) begin
      n_bad++; $display("FAIL midreset_stat: got %h/%0d want aa/0", fsm_stat, CntFrame);
    end
    RESET = 1'b0;
    FSMIND1 = 1'b0;
    repeat (30) begin
      @(negedge CLKMPRE);
      if (FSMIND0 !== 1'b0) n_ind0++;
    end
    n_cmp++;
    if (n_ind0 !== 0 || fsm_stat !== 8'h01) begin
      n_bad++; $display("FAIL midreset_nohandback: got %0d/%h want 0/01", n_ind0, fsm_stat);
    end
  endtask

  task automatic test_back_to_back();
    int total;
    int k_rel;
    total = 0;
    for (int f = 0; f < 3; f++) begin
      if (f > 0) @(negedge CLKMPRE);
      run_frame(1'b0, 7, -5);
      total += n_done;
      n_cmp++;
      if (n_adc !== 160 || k_hb !== 6084 || k_ack !== 3) begin
        n_bad++; $display("FAIL b2b_frame%0d: got adc %0d hb %0d ack %0d want 160/6084/3",
                          f, n_adc, k_hb, k_ack);
      end
      do_release(k_rel);
    end
    n_cmp++;
    if (CntFrame !== 32'd3) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 3", CntFrame); end
    n_cmp++;
    if (total !== 480) begin n_bad++; $display("FAIL b2b_done: got %0d want 480", total); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_fifo_stall();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
